// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes a BCD ones/tens digit pair onto a 2-digit common-anode
// 7-segment display. A snapshot of both digits is taken once per frame, at the
// end of the tens slot, so a frame never mixes old and new digits. Each digit
// slot starts with GUARD cycles of all anodes off, so segment changes never
// ghost onto the neighbouring digit.
// Optional feature macro: LEADING_ZERO_BLANK_EN -- when defined, a tens digit
// of 0 leaves the tens slot dark (anodes and segments inactive). Slot timing
// is the same either way.
// seg, an and frame_tick are flop outputs. Pin polarity is applied before the
// flops, so the pins never glitch.
module seg7_scan_driver #(
   parameter int REFRESH_DIV    = 50000,
   parameter int GUARD          = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] ones,
   input  logic [3:0] tens,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame_tick,
   output logic       state_dbg
);

   localparam int               CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
   localparam logic [6:0]       SEG_MASK  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [1:0]       AN_MASK   = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

   typedef enum logic {
      S_ONES = 1'b0,
      S_TENS = 1'b1
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       snap_ones_q, snap_tens_q;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       an_q, an_d;
   logic             tick_q, tick_d;
   logic             wrap;
   logic             show;
   logic [3:0]       digit;
   logic [6:0]       seg_act;
   logic [1:0]       an_act;

   // BCD to active-high {g,f,e,d,c,b,a}; non-decimal codes show a dash.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // Next counter value and the pin values for the current (state, cnt, snapshot).
   always_comb begin
      wrap    = (cnt_q == CNT_MAX);
      cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
      digit   = (state_q == S_TENS) ? snap_tens_q : snap_ones_q;
      show    = (cnt_q >= CNT_GUARD);
`ifdef LEADING_ZERO_BLANK_EN
      if ((state_q == S_TENS) && (snap_tens_q == 4'd0)) show = 1'b0;
`endif
      seg_act = show ? bcd_to_seg(digit) : 7'h00;
      an_act  = show ? ((state_q == S_TENS) ? 2'b10 : 2'b01) : 2'b00;
      seg_d   = seg_act ^ SEG_MASK;
      an_d    = an_act ^ AN_MASK;
      tick_d  = wrap && (state_q == S_TENS);
   end

   // Slot FSM, frame snapshot and registered pin drivers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_ONES;
         cnt_q       <= '0;
         snap_ones_q <= 4'd0;
         snap_tens_q <= 4'd0;
         seg_q       <= SEG_MASK;
         an_q        <= AN_MASK;
         tick_q      <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
         tick_q <= tick_d;
         if (wrap) begin
            case (state_q)
               S_ONES: state_q <= S_TENS;
               default: begin
                  state_q     <= S_ONES;
                  snap_ones_q <= ones;
                  snap_tens_q <= tens;
               end
            endcase
         end
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = tick_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Randomized and directed stimulus for seg7_scan_driver. The reference model
// works from elapsed cycles since reset release: slot, position and frame
// number come from division, and the displayed digits come from the input
// history at the last cycle of the previous frame.
// Build with +define+LEADING_ZERO_BLANK_EN to exercise the blanking variant.
module tb_seg7_scan_driver;

  localparam int R = 8;
  localparam int G = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ones, tens;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;
  logic       state_dbg;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .REFRESH_DIV   (R),
    .GUARD         (G),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ones      (ones),
    .tens      (tens),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;             // posedges since reset release
  logic [7:0] hist [0:4095];         // {tens, ones} driven during cycle k

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] t [0:15];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    return t[d];
  endfunction

  // ---------------- reference model ----------------
  // Pins expected just after posedge number n (n >= 1) since reset release.
  task automatic model(input int n, output logic [6:0] es, output logic [1:0] ea,
                       output logic et);
    int         m, pos, slot, frame;
    logic [7:0] snap;
    logic [3:0] d;
    logic       show;
    m     = n - 1;
    pos   = m % R;
    slot  = (m / R) % 2;
    frame = m / (2 * R);
    snap  = (frame == 0) ? 8'h00 : hist[frame * 2 * R - 1];
    d     = (slot == 1) ? snap[7:4] : snap[3:0];
    show  = (pos >= G);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 1 && snap[7:4] == 4'd0) show = 1'b0;
`endif
    es = show ? (~dec(d) & 7'h7F) : 7'h7F;
    ea = show ? ((slot == 1) ? 2'b01 : 2'b10) : 2'b11;
    et = (n % (2 * R) == 0);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    logic [6:0] es;
    logic [1:0] ea;
    logic       et;
    hist[cyc] = {tens, ones};
    @(posedge clk);
    #1;
    cyc++;
    model(cyc, es, ea, et);
    check_eq("seg", seg, es);
    check_eq("an", an, ea);
    check_eq("frame_tick", frame_tick, et);
    check_eq("an_never_both", an == 2'b00, 1'b0);
    if (an == 2'b11) check_eq("seg_off_when_dark", seg, 7'h7F);
  endtask

  task automatic rand_inputs();
    ones = 4'($urandom_range(0, 15));
    tens = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
  endtask

  task automatic check_reset_pins(input string tag);
    check_eq({tag, "_seg"}, seg, 7'h7F);
    check_eq({tag, "_an"}, an, 2'b11);
    check_eq({tag, "_tick"}, frame_tick, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst  = 1'b0;
    ones = 4'd0;
    tens = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("reset");
    check_eq("reset_state", state_dbg, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;

    // zero digits after reset
    repeat (20) step();
    // new digits mid-frame: must wait for the frame boundary
    ones = 4'd7; tens = 4'd4;
    repeat (40) step();
    // non-decimal code shows a dash
    ones = 4'hC;
    repeat (32) step();
    // tens zero (blanked in the blanking build)
    ones = 4'd5; tens = 4'd0;
    repeat (40) step();
    // random traffic, inputs changing at arbitrary cycles
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) rand_inputs();
      step();
    end

    // asynchronous reset at cnt=5 of the tens slot
    ones = 4'd9; tens = 4'd8;
    for (int i = 0; i < 16 && (cyc % (2 * R)) != (R + 5); i++) step();
    check_eq("reached_tens_cnt5", cyc % (2 * R), R + 5);
    #2;
    rst = 1'b0;
    #1;
    check_reset_pins("async_reset");
    check_eq("async_reset_state", state_dbg, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_pins("held_reset");
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    // first frame after release shows zeros, then the held 9/8
    repeat (24) step();
    check_eq("restart_state_tens", state_dbg, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) rand_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
